gear_shift_controller: RTL and testbench

- Upstream stage of the dashboard display unit; produces `gear_char` (lever position) and `gear_num` (automatic gear 1..6) from driver lever buttons, brake, and vehicle speed.
- Implements the PRND lever state machine with safety interlocks.
- In D, implements a speed-based automatic shift scheduler with hysteresis and a post-shift hold timer.

---
 rtl/gear_shift_controller.sv | 208 ++++++++++++++++++++
 tb/tb_gear_shift_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gear_shift_controller.sv
// PRND lever state machine with safety interlocks, plus a speed-based automatic
// shift scheduler (hysteresis and post-shift hold) that runs while the lever is in D.
module gear_shift_controller #(
    parameter int UP_STEP    = 20,
    parameter int HYST       = 5,
    parameter int HOLD_TICKS = 500,
    parameter int HOLD_W     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       brake,
    input  logic [7:0] speed,
    output logic [3:0] gear_char,
    output logic [2:0] gear_num,
    output logic       shift_evt,
    output logic       reject_evt
);

    localparam logic [3:0] ST_P = 4'd3;
    localparam logic [3:0] ST_R = 4'd6;
    localparam logic [3:0] ST_N = 4'd9;
    localparam logic [3:0] ST_D = 4'd12;

    logic [1:0]        up_sync_r;
    logic [1:0]        dn_sync_r;
    logic              up_prev_r;
    logic              dn_prev_r;
    logic [3:0]        gear_char_r;
    logic [2:0]        gear_num_r;
    logic              shift_evt_r;
    logic              reject_evt_r;
    logic [HOLD_W-1:0] hold_r;

    logic              up_req_s;
    logic              dn_req_s;
    logic              single_up_s;
    logic              single_dn_s;
    logic              speed_zero_s;
    logic [3:0]        char_nxt_s;
    logic              lever_acc_s;
    logic              lever_rej_s;
    logic [8:0]        speed9_s;
    logic [8:0]        up_thr_s;
    logic [8:0]        dn_base_s;
    logic              up_ok_s;
    logic              dn_ok_s;
    logic              auto_en_s;

    // Gear matching the current speed when D is entered: largest g with speed >= (g-1)*UP_STEP.
    function automatic logic [2:0] entry_gear(input logic [7:0] spd);
        logic [2:0] g;
        g = 3'd1;
        for (int i = 2; i <= 6; i++) begin
            if ({1'b0, spd} >= 9'((i - 1) * UP_STEP)) begin
                g = 3'(i);
            end else begin
                g = g;
            end
        end
        return g;
    endfunction

    // Two-flop synchronisers and rising-edge history for both lever buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_sync_r <= 2'b00;
            dn_sync_r <= 2'b00;
            up_prev_r <= 1'b0;
            dn_prev_r <= 1'b0;
        end else begin
            up_sync_r <= {up_sync_r[0], btn_up};
            dn_sync_r <= {dn_sync_r[0], btn_down};
            up_prev_r <= up_sync_r[1];
            dn_prev_r <= dn_sync_r[1];
        end
    end

    assign up_req_s     = up_sync_r[1] & ~up_prev_r;
    assign dn_req_s     = dn_sync_r[1] & ~dn_prev_r;
    // Coincident up and down requests cancel each other.
    assign single_up_s  = up_req_s & ~dn_req_s;
    assign single_dn_s  = dn_req_s & ~up_req_s;
    assign speed_zero_s = (speed == 8'd0);

    // Lever transition and interlock evaluation.
    always_comb begin
        char_nxt_s  = gear_char_r;
        lever_acc_s = 1'b0;
        lever_rej_s = 1'b0;
        case (gear_char_r)
            ST_P: begin
                if (single_dn_s) begin
                    if (brake && speed_zero_s) begin
                        char_nxt_s  = ST_R;
                        lever_acc_s = 1'b1;
                    end else begin
                        lever_rej_s = 1'b1;
                    end
                end else begin
                    lever_acc_s = 1'b0;
                end
            end
            ST_R: begin
                if (single_dn_s) begin
                    char_nxt_s  = ST_N;
                    lever_acc_s = 1'b1;
                end else if (single_up_s) begin
                    if (speed_zero_s && brake) begin
                        char_nxt_s  = ST_P;
                        lever_acc_s = 1'b1;
                    end else begin
                        lever_rej_s = 1'b1;
                    end
                end else begin
                    lever_acc_s = 1'b0;
                end
            end
            ST_N: begin
                if (single_dn_s) begin
                    if (!speed_zero_s || brake) begin
                        char_nxt_s  = ST_D;
                        lever_acc_s = 1'b1;
                    end else begin
                        lever_rej_s = 1'b1;
                    end
                end else if (single_up_s) begin
                    if (speed_zero_s) begin
                        char_nxt_s  = ST_R;
                        lever_acc_s = 1'b1;
                    end else begin
                        lever_rej_s = 1'b1;
                    end
                end else begin
                    lever_acc_s = 1'b0;
                end
            end
            ST_D: begin
                if (single_up_s) begin
                    char_nxt_s  = ST_N;
                    lever_acc_s = 1'b1;
                end else begin
                    lever_acc_s = 1'b0;
                end
            end
            default: begin
                char_nxt_s  = ST_P;
                lever_acc_s = 1'b1;
            end
        endcase
    end

    // Downshift threshold base is guarded so a small gear never wraps into a huge limit.
    assign speed9_s  = {1'b0, speed};
    assign up_thr_s  = 9'(gear_num_r) * 9'(UP_STEP);
    assign dn_base_s = (9'(gear_num_r) - 9'd1) * 9'(UP_STEP);
    assign up_ok_s   = (gear_num_r < 3'd6) && (speed9_s >= up_thr_s);
    assign dn_ok_s   = (gear_num_r > 3'd1) && (dn_base_s >= 9'(HYST))
                       && (speed9_s < (dn_base_s - 9'(HYST)));
    assign auto_en_s = (gear_char_r == ST_D) && (hold_r == {HOLD_W{1'b0}});

    // Lever state, automatic gear, hold timer and event pulses; lever moves win over auto-shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gear_char_r  <= ST_P;
            gear_num_r   <= 3'd0;
            shift_evt_r  <= 1'b0;
            reject_evt_r <= 1'b0;
            hold_r       <= {HOLD_W{1'b0}};
        end else begin
            reject_evt_r <= lever_rej_s;
            if (lever_acc_s) begin
                gear_char_r <= char_nxt_s;
                shift_evt_r <= 1'b1;
                if (char_nxt_s == ST_D) begin
                    gear_num_r <= entry_gear(speed);
                    hold_r     <= HOLD_W'(HOLD_TICKS);
                end else begin
                    gear_num_r <= 3'd0;
                    hold_r     <= {HOLD_W{1'b0}};
                end
            end else if (auto_en_s && up_ok_s) begin
                gear_num_r  <= gear_num_r + 3'd1;
                hold_r      <= HOLD_W'(HOLD_TICKS);
                shift_evt_r <= 1'b1;
            end else if (auto_en_s && dn_ok_s) begin
                gear_num_r  <= gear_num_r - 3'd1;
                hold_r      <= HOLD_W'(HOLD_TICKS);
                shift_evt_r <= 1'b1;
            end else begin
                shift_evt_r <= 1'b0;
                if (tick_ms && (hold_r != {HOLD_W{1'b0}})) begin
                    hold_r <= hold_r - HOLD_W'(1);
                end else begin
                    hold_r <= hold_r;
                end
            end
        end
    end

    assign gear_char  = gear_char_r;
    assign gear_num   = gear_num_r;
    assign shift_evt  = shift_evt_r;
    assign reject_evt = reject_evt_r;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Scoreboard bench for gear_shift_controller: expected events are queued as stimulus
// is driven and popped whenever the DUT pulses shift_evt or reject_evt.
module tb_gear_shift_controller;

    localparam int HOLD_TICKS = 500;

    logic       clk;
    logic       rst;
    logic       tick_ms;
    logic       btn_up;
    logic       btn_down;
    logic       brake;
    logic [7:0] speed;
    logic [3:0] gear_char;
    logic [2:0] gear_num;
    logic       shift_evt;
    logic       reject_evt;

    typedef struct {
        bit rej;
        int ch;
        int num;
        bit auto_s;
    } evt_t;

    evt_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   tick_total = 0;
    int   last_evt_t = 0;

    gear_shift_controller #(
        .UP_STEP(20), .HYST(5), .HOLD_TICKS(HOLD_TICKS), .HOLD_W(10)
    ) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .btn_up(btn_up), .btn_down(btn_down),
        .brake(brake), .speed(speed), .gear_char(gear_char), .gear_num(gear_num),
        .shift_evt(shift_evt), .reject_evt(reject_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle tick every other clock
    initial begin
        tick_ms = 1'b0;
        forever begin
            @(posedge clk);
            #1 tick_ms = ~tick_ms;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void push(input bit rej, input int ch, input int num, input bit au);
        evt_t e;
        e.rej = rej;
        e.ch = ch;
        e.num = num;
        e.auto_s = au;
        exp_q.push_back(e);
    endfunction

    // Monitor: every event pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (shift_evt || reject_evt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_evt", {30'd0, shift_evt, reject_evt}, 0);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    check("evt_reject", int'(reject_evt), int'(e.rej));
                    check("evt_shift", int'(shift_evt), int'(!e.rej));
                    check("evt_char", int'(gear_char), e.ch);
                    check("evt_num", int'(gear_num), e.num);
                    if (e.auto_s) begin
                        check("hold_gap_ok", int'((tick_total - last_evt_t) >= HOLD_TICKS), 1);
                    end
                end
                last_evt_t = tick_total;
            end
            if (tick_ms) tick_total++;
        end
    end

    task automatic press(input bit up, input bit dn);
        btn_up = up;
        btn_down = dn;
        repeat (6) @(negedge clk);
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        brake = 1'b0;
        speed = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_char", int'(gear_char), 3);
        check("rst_num", int'(gear_num), 0);
        check("rst_shift", int'(shift_evt), 0);
        check("rst_reject", int'(reject_evt), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // P release refused without brake
        push(1'b1, 3, 0, 1'b0);
        press(1'b0, 1'b1);
        drain(20);
        check("p_interlock_char", int'(gear_char), 3);

        // P -> R -> N -> D
        brake = 1'b1;
        push(1'b0, 6, 0, 1'b0);
        press(1'b0, 1'b1);
        push(1'b0, 9, 0, 1'b0);
        press(1'b0, 1'b1);
        push(1'b0, 12, 1, 1'b0);
        press(1'b0, 1'b1);
        drain(20);
        check("d_entry_num", int'(gear_num), 1);
        press(1'b0, 1'b1);
        check("down_in_d_char", int'(gear_char), 12);

        // Slow ramp 0 -> 60
        brake = 1'b0;
        for (int s = 1; s <= 60; s++) begin
            speed = 8'(s);
            if (s == 20) push(1'b0, 12, 2, 1'b1);
            if (s == 40) push(1'b0, 12, 3, 1'b1);
            if (s == 60) push(1'b0, 12, 4, 1'b1);
            repeat (80) @(negedge clk);
        end
        drain(20);
        check("ramp_num", int'(gear_num), 4);

        // Downshift with hysteresis
        speed = 8'd50;
        push(1'b0, 12, 3, 1'b1);
        drain(3000);
        speed = 8'd36;
        repeat (1200) @(negedge clk);
        check("hyst_36_num", int'(gear_num), 3);
        speed = 8'd34;
        push(1'b0, 12, 2, 1'b1);
        drain(3000);
        speed = 8'd15;
        repeat (1200) @(negedge clk);
        check("hyst_15_num", int'(gear_num), 2);
        speed = 8'd14;
        push(1'b0, 12, 1, 1'b1);
        drain(3000);

        // D -> N at speed, N -> R interlock, R -> P interlock
        push(1'b0, 9, 0, 1'b0);
        press(1'b1, 1'b0);
        speed = 8'd10;
        push(1'b1, 9, 0, 1'b0);
        press(1'b1, 1'b0);
        drain(20);
        check("n_rev_interlock_char", int'(gear_char), 9);
        speed = 8'd0;
        push(1'b0, 6, 0, 1'b0);
        press(1'b1, 1'b0);
        push(1'b1, 6, 0, 1'b0);
        press(1'b1, 1'b0);
        brake = 1'b1;
        push(1'b0, 3, 0, 1'b0);
        press(1'b1, 1'b0);
        drain(20);
        press(1'b1, 1'b0);
        check("up_in_p_char", int'(gear_char), 3);

        // Back to N, then N -> D interlock and simultaneous buttons
        push(1'b0, 6, 0, 1'b0);
        press(1'b0, 1'b1);
        push(1'b0, 9, 0, 1'b0);
        press(1'b0, 1'b1);
        brake = 1'b0;
        push(1'b1, 9, 0, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        drain(20);
        check("simul_char", int'(gear_char), 9);

        // N -> D while rolling picks gear from speed, then upshift to 4
        speed = 8'd50;
        push(1'b0, 12, 3, 1'b0);
        press(1'b0, 1'b1);
        speed = 8'd70;
        push(1'b0, 12, 4, 1'b1);
        drain(3000);

        // Asynchronous reset mid-hold
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_char", int'(gear_char), 3);
        check("arst_num", int'(gear_num), 0);
        check("arst_shift", int'(shift_evt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        // Speed jump: one gear step per hold period
        brake = 1'b1;
        speed = 8'd0;
        push(1'b0, 6, 0, 1'b0);
        press(1'b0, 1'b1);
        push(1'b0, 9, 0, 1'b0);
        press(1'b0, 1'b1);
        push(1'b0, 12, 1, 1'b0);
        press(1'b0, 1'b1);
        speed = 8'd200;
        for (int g = 2; g <= 6; g++) push(1'b0, 12, g, 1'b1);
        drain(7000);
        check("jump_num", int'(gear_num), 6);
        push(1'b0, 9, 0, 1'b0);
        press(1'b1, 1'b0);
        drain(20);
        check("final_char", int'(gear_char), 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
